// File: rtl/usf_pkg.sv
// Shared types and sizing helpers for the unlimited-sampling reconstruction sequencer.
package usf_pkg;

    localparam int unsigned USF_WIDTH  = 16;
    localparam int unsigned USF_LAMBDA = 10;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } seq_state_t;

    // Alignment FIFO depth: DP_LATENCY+2 rounded up to a power of two.
    function automatic int unsigned fifo_depth(input int unsigned latency);
        return 1 << $clog2(latency + 2);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned frame_len);
        return $clog2(frame_len);
    endfunction

endpackage

// File: rtl/usf_align_fifo.sv
// Synchronous FIFO that holds y[k] while its residual is in flight through the datapath.
module usf_align_fifo
    import usf_pkg::*;
#(
    parameter int unsigned WIDTH = USF_WIDTH,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/usf_recon_sequencer.sv
// Frame controller for the unlimited-sampling reconstruction datapath.
// Optional DRAIN watchdog enabled by defining USF_SEQ_WATCHDOG_EN.
module usf_recon_sequencer
    import usf_pkg::*;
#(
    parameter int unsigned WIDTH      = USF_WIDTH,
    parameter int unsigned LAMBDA     = USF_LAMBDA,
    parameter int unsigned FRAME_LEN  = 64,
    parameter int unsigned DP_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_diff,
    input  logic signed [WIDTH-1:0] in_y,
    output logic                    dp_rst,
    output logic                    dp_valid,
    output logic signed [WIDTH-1:0] dp_diff,
    input  logic                    dp_valid_out,
    input  logic signed [WIDTH-1:0] dp_residual,
    output logic                    out_valid,
    output logic signed [WIDTH:0]   out_data,
    output logic                    out_last,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int unsigned FIFO_DEPTH = fifo_depth(DP_LATENCY);
    localparam int unsigned CW         = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    if (FRAME_LEN < 2 || LAMBDA == 0) begin : g_param_check
        $error("usf_recon_sequencer: FRAME_LEN must be >= 2 and LAMBDA nonzero");
    end

    seq_state_t       state_q, state_d;
    logic [CW-1:0]    in_cnt_q, out_cnt_q;
    logic             accept;
    logic             wd_expired;
    logic             fifo_empty, fifo_full;
    logic [WIDTH-1:0] fifo_head;

    assign accept   = in_valid && in_ready;
    assign dp_valid = accept;
    assign dp_diff  = accept ? in_diff : '0;

    // Residuals arriving outside an active frame or with nothing queued are dropped.
    assign out_valid = dp_valid_out && !fifo_empty && (state_q == STREAM || state_q == DRAIN);
    assign out_data  = out_valid ? ({fifo_head[WIDTH-1], fifo_head}
                                    + {dp_residual[WIDTH-1], dp_residual}) : '0;
    assign out_last  = out_valid && (out_cnt_q == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        dp_rst     = reset;
        busy       = 1'b1;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
                dp_rst  = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                in_ready = !fifo_full;
                if (in_valid && !fifo_full && in_cnt_q == LAST_IDX) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_valid && out_cnt_q == LAST_IDX) state_d = DONE;
                else if (wd_expired)                    state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (accept)    in_cnt_q  <= in_cnt_q + CW'(1);
            if (out_valid) out_cnt_q <= out_cnt_q + CW'(1);
        end
    end

`ifdef USF_SEQ_WATCHDOG_EN
    localparam int unsigned WD_LIMIT = DP_LATENCY + 4;
    localparam int unsigned WDW      = $clog2(WD_LIMIT + 1);

    logic [WDW-1:0] wd_q;
    logic           err_q;

    // wd_q counts cycles since the last dp_valid_out, starting at 1 on the cycle after it.
    assign wd_expired  = (state_q == DRAIN) && !dp_valid_out && (wd_q == WDW'(WD_LIMIT - 1));
    assign err_timeout = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q  <= WDW'(1);
            err_q <= 1'b0;
        end else begin
            if (state_q != DRAIN || dp_valid_out) wd_q <= WDW'(1);
            else                                  wd_q <= wd_q + WDW'(1);
            if (state_q == IDLE && start) err_q <= 1'b0;
            else if (wd_expired)          err_q <= 1'b1;
        end
    end
`else
    assign wd_expired  = 1'b0;
    assign err_timeout = 1'b0;
`endif

    usf_align_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_align_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q == CLEAR),
        .push      (accept),
        .push_data (in_y),
        .pop       (out_valid),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_usf_recon_sequencer.sv
// Bench for usf_recon_sequencer: datapath stand-in plus a timeline scoreboard of the frame.
module tb_usf_recon_sequencer;

    localparam int W      = 16;
    localparam int FL     = 8;
    localparam int LAT    = 4;
    localparam int LAMBDA = 10;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] in_diff = '0;
    logic signed [W-1:0] in_y = '0;
    logic                in_ready, dp_rst, dp_valid, out_valid, out_last;
    logic                frame_done, busy, err_timeout;
    logic signed [W-1:0] dp_diff;
    logic                dp_valid_out;
    logic signed [W-1:0] dp_residual;
    logic signed [W:0]   out_data;

    always #5 clk = ~clk;

    usf_recon_sequencer #(
        .WIDTH      (W),
        .LAMBDA     (LAMBDA),
        .FRAME_LEN  (FL),
        .DP_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_diff      (in_diff),
        .in_y         (in_y),
        .dp_rst       (dp_rst),
        .dp_valid     (dp_valid),
        .dp_diff      (dp_diff),
        .dp_valid_out (dp_valid_out),
        .dp_residual  (dp_residual),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .frame_done   (frame_done),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc,
                     $signed(act), $signed(exp));
        end
    endfunction

    function automatic int round_m(input int v);
        int m;
        m = 2 * LAMBDA;
        if (v >= 0) return ((v + m / 2) / m) * m;
        return -(((-v + m / 2) / m) * m);
    endfunction

    function automatic int trunc16(input int v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return int'(t);
    endfunction

    // Datapath stand-in: double integration rounded to multiples of 2*LAMBDA, LAT cycles deep.
    int                  s1 = 0, s2 = 0, emitted = 0, wd_limit = 0;
    logic [LAT-1:0]      pv = '0;
    logic signed [W-1:0] pr [LAT];

    always @(posedge clk) begin
        if (dp_rst) begin
            s1      <= 0;
            s2      <= 0;
            pv      <= '0;
            emitted <= 0;
        end else begin
            s1    <= s1 + int'(dp_diff);
            s2    <= s2 + s1 + int'(dp_diff);
            pv    <= {pv[LAT-2:0], dp_valid};
            pr[0] <= W'(round_m(s2 + s1 + int'(dp_diff)));
            for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
            if (pv[LAT-1]) emitted <= emitted + 1;
        end
    end

    assign dp_valid_out = pv[LAT-1] && !(wd_limit > 0 && emitted >= wd_limit);
    assign dp_residual  = pr[LAT-1];

    // Scoreboard state, expressed as a frame timeline.
    typedef struct {
        int due;
        int data;
        bit last;
    } exp_t;

    exp_t outq[$];
    bit   frame_on = 1'b0, m_err = 1'b0, wd_frame = 1'b0;
    int   start_cyc = -100, acc_cnt = 0, n_out = 0, done_cyc = -1, done_at = 0;
    int   last_out_cyc = 0, frames_done = 0, m_s1 = 0, m_s2 = 0;
    int   rec [FL];

    initial begin : compare
        bit   idle, exp_clear, exp_ready, acc, exp_ov, exp_fd;
        int   exp_diff;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                frame_on = 1'b0;
                outq.delete();
                m_err    = 1'b0;
                done_cyc = -1;
                acc_cnt  = 0;
                chk("rst_dp_rst", dp_rst, 1);
                chk("rst_in_ready", in_ready, 0);
                chk("rst_dp_valid", dp_valid, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_data", int'(out_data), 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_frame_done", frame_done, 0);
                chk("rst_busy", busy, 0);
                chk("rst_err", err_timeout, 0);
            end else begin
                idle      = !frame_on;
                exp_clear = frame_on && cyc == start_cyc + 1;
                exp_ready = frame_on && cyc >= start_cyc + 2 && acc_cnt < FL;
                acc       = in_valid && exp_ready;
                exp_diff  = acc ? int'(in_diff) : 0;
                exp_ov    = outq.size() > 0 && outq[0].due == cyc;
                exp_fd    = frame_on && cyc == done_cyc;
                if (exp_fd && wd_frame) m_err = 1'b1;

                chk("dp_rst", dp_rst, exp_clear);
                chk("in_ready", in_ready, exp_ready);
                chk("dp_valid", dp_valid, acc);
                chk("dp_diff", int'(dp_diff), exp_diff);
                chk("out_valid", out_valid, exp_ov);
                chk("frame_done", frame_done, exp_fd);
                chk("busy", busy, frame_on);
                chk("err_timeout", err_timeout, m_err);
                if (exp_ov) begin
                    chk("out_data", int'(out_data), outq[0].data);
                    chk("out_last", out_last, outq[0].last);
                    if (n_out < FL) rec[n_out] = int'(out_data);
                    n_out++;
                    last_out_cyc = cyc;
                    if (outq[0].last) done_cyc = cyc + 1;
                    void'(outq.pop_front());
                    if (wd_frame && n_out == wd_limit) done_cyc = cyc + LAT + 4;
                end else begin
                    chk("out_data_idle", int'(out_data), 0);
                    chk("out_last_idle", out_last, 0);
                end

                if (exp_clear) begin
                    m_s1 = 0;
                    m_s2 = 0;
                end else begin
                    m_s1 = m_s1 + exp_diff;
                    m_s2 = m_s2 + m_s1;
                end
                if (acc) begin
                    e.due  = cyc + LAT;
                    e.data = int'(in_y) + trunc16(round_m(m_s2));
                    e.last = (acc_cnt == FL - 1);
                    if (!(wd_frame && acc_cnt >= wd_limit)) outq.push_back(e);
                    acc_cnt++;
                end
                if (exp_fd) begin
                    frame_on = 1'b0;
                    done_at  = cyc;
                    frames_done++;
                end
                if (start && idle) begin
                    frame_on  = 1'b1;
                    start_cyc = cyc;
                    acc_cnt   = 0;
                    n_out     = 0;
                    m_err     = 1'b0;
                    done_cyc  = -1;
                    wd_frame  = (wd_limit > 0);
                    outq.delete();
                end
            end
            cyc++;
        end
    end

    logic signed [W-1:0] ys [FL];
    logic signed [W-1:0] ds [FL];

    task automatic fill_ramp(input int d0);
        for (int k = 0; k < FL; k++) begin
            ys[k] = W'(3 + k);
            ds[k] = '0;
        end
        ds[0] = W'(d0);
    endtask

    // mode 0: continuous, 1: alternating gaps, 2: random gaps. Entered at posedge+1.
    task automatic run_frame(input int mode, input bit noise, input int rst_after);
        int n, fd0, idx;
        fd0      = frames_done;
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 0;
        while (frames_done == fd0 && n < 300) begin
            if (rst_after > 0 && acc_cnt == rst_after) begin
                in_valid = 1'b0;
                reset    = 1'b1;
                #1;
                chk("midrst_dp_rst", dp_rst, 1);
                chk("midrst_out_valid", out_valid, 0);
                chk("midrst_busy", busy, 0);
                chk("midrst_in_ready", in_ready, 0);
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b0;
                chk("midrst_no_frame_done", frames_done, fd0);
                return;
            end
            idx = (acc_cnt < FL) ? acc_cnt : FL - 1;
            if (mode == 0)      in_valid = 1'b1;
            else if (mode == 1) in_valid = ((n % 2) == 0);
            else                in_valid = ($urandom_range(0, 99) < 60);
            in_y    = ys[idx];
            in_diff = ds[idx];
            start   = noise && ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("frame_complete", n < 300, 1);
    endtask

    initial begin : main
        int prev_start, fd0, d;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        fill_ramp(0);
        run_frame(0, 1'b0, 0);
        chk("ramp_first", rec[0], 3);
        chk("ramp_last", rec[FL-1], 10);
        chk("ramp_start_to_done", done_at - start_cyc, FL + LAT + 2);

        fill_ramp(20);
        run_frame(0, 1'b0, 0);
        chk("step_first", rec[0], 23);
        chk("step_last", rec[FL-1], 170);

        prev_start = start_cyc;
        run_frame(0, 1'b0, 0);
        chk("b2b_period", start_cyc - prev_start, FL + LAT + 3);
        chk("b2b_first", rec[0], 23);
        chk("b2b_last", rec[FL-1], 170);

        fill_ramp(0);
        run_frame(1, 1'b0, 0);
        chk("gaps_count", n_out, FL);
        chk("gaps_first", rec[0], 3);
        chk("gaps_last", rec[FL-1], 10);

        fd0 = frames_done;
        run_frame(0, 1'b1, 0);
        chk("noise_single_done", frames_done - fd0, 1);

        run_frame(0, 1'b0, 3);
        repeat (2) @(posedge clk);
        #1;
        run_frame(0, 1'b0, 0);
        chk("post_rst_count", n_out, FL);
        chk("post_rst_first", rec[0], 3);
        chk("post_rst_last", rec[FL-1], 10);

        for (int f = 0; f < 12; f++) begin
            for (int k = 0; k < FL; k++) begin
                ys[k] = W'($urandom);
                d     = int'($urandom_range(0, 1000)) - 500;
                ds[k] = W'(d);
            end
            run_frame(2, ($urandom_range(0, 1) == 1), 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

`ifdef USF_SEQ_WATCHDOG_EN
        fill_ramp(0);
        wd_limit = 5;
        run_frame(0, 1'b0, 0);
        chk("wd_err_set", err_timeout, 1);
        chk("wd_outputs", n_out, 5);
        chk("wd_gap", done_at - last_out_cyc, 8);
        wd_limit = 0;
        run_frame(0, 1'b0, 0);
        chk("wd_err_cleared", err_timeout, 0);
        chk("wd_next_count", n_out, FL);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
